// File: rtl/rs_age_issue_if.sv
// rtl/rs_age_issue_if.sv - dispatch, CDB broadcast and issue bundle of the age-ordered reservation station
interface rs_age_issue_if #(
   parameter int DISPATCH_W = 2,
   parameter int CDB_W      = 2,
   parameter int ISSUE_W    = 2,
   parameter int DATA_W     = 32,
   parameter int PRN_W      = 6,
   parameter int ROB_W      = 5,
   parameter int FUNC_W     = 4
) ();
   logic [DISPATCH_W-1:0]        disp_valid;
   logic [DISPATCH_W-1:0]        disp_op1_ready;
   logic [DISPATCH_W-1:0]        disp_op2_ready;
   logic [DISPATCH_W*DATA_W-1:0] disp_op1;
   logic [DISPATCH_W*DATA_W-1:0] disp_op2;
   logic [DISPATCH_W*PRN_W-1:0]  disp_dest_prn;
   logic [DISPATCH_W*ROB_W-1:0]  disp_rob;
   logic [DISPATCH_W*FUNC_W-1:0] disp_func;

   logic [CDB_W-1:0]             cdb_valid;
   logic [CDB_W*PRN_W-1:0]       cdb_prn;
   logic [CDB_W*DATA_W-1:0]      cdb_value;

   logic [ISSUE_W-1:0]           fu_avail;
   logic [ISSUE_W-1:0]           iss_valid;
   logic [ISSUE_W*DATA_W-1:0]    iss_op1;
   logic [ISSUE_W*DATA_W-1:0]    iss_op2;
   logic [ISSUE_W*PRN_W-1:0]     iss_dest_prn;
   logic [ISSUE_W*ROB_W-1:0]     iss_rob;
   logic [ISSUE_W*FUNC_W-1:0]    iss_func;

   modport master (
      output disp_valid, disp_op1_ready, disp_op2_ready, disp_op1, disp_op2,
      output disp_dest_prn, disp_rob, disp_func,
      output cdb_valid, cdb_prn, cdb_value, fu_avail,
      input  iss_valid, iss_op1, iss_op2, iss_dest_prn, iss_rob, iss_func
   );

   modport slave (
      input  disp_valid, disp_op1_ready, disp_op2_ready, disp_op1, disp_op2,
      input  disp_dest_prn, disp_rob, disp_func,
      input  cdb_valid, cdb_prn, cdb_value, fu_avail,
      output iss_valid, iss_op1, iss_op2, iss_dest_prn, iss_rob, iss_func
   );
endinterface

// File: rtl/rs_age_issue.sv
// rtl/rs_age_issue.sv - reservation station with multi-lane dispatch, CDB wakeup/bypass and oldest-first issue
// Age is a pairwise matrix: older_q[i][j]=1 means entry j is older than entry i.
module rs_age_issue #(
   parameter int ENTRIES    = 16,
   parameter int DISPATCH_W = 2,
   parameter int CDB_W      = 2,
   parameter int ISSUE_W    = 2,
   parameter int DATA_W     = 32,
   parameter int PRN_W      = 6,
   parameter int ROB_W      = 5,
   parameter int FUNC_W     = 4,
   localparam int CNT_W     = $clog2(ENTRIES + 1),
   localparam int IDX_W     = $clog2(ENTRIES)
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              flush_i,
   rs_age_issue_if.slave     rs_if,
   output logic [CNT_W-1:0]  free_cnt_o,
   output logic              almost_full_o,
   output logic              overflow_err_o
);

   logic [ENTRIES-1:0]                valid_q, valid_d;
   logic [ENTRIES-1:0]                rdy1_q, rdy1_d, rdy2_q, rdy2_d;
   logic [ENTRIES-1:0][DATA_W-1:0]    op1_q, op1_d, op2_q, op2_d;
   logic [ENTRIES-1:0][PRN_W-1:0]     dest_q, dest_d;
   logic [ENTRIES-1:0][ROB_W-1:0]     rob_q, rob_d;
   logic [ENTRIES-1:0][FUNC_W-1:0]    func_q, func_d;
   logic [ENTRIES-1:0][ENTRIES-1:0]   older_q, older_d;
   logic [CNT_W-1:0]                  free_q, free_d;
   logic                              ovf_q, ovf_d;

   logic [ENTRIES-1:0]                ready, issued, taken, new_mask;
   logic [ENTRIES-1:0][CNT_W-1:0]     rank;
   logic [ISSUE_W-1:0][CNT_W-1:0]     slot;
   logic [ENTRIES-1:0][DATA_W:0]      wake1, wake2;
   logic [DISPATCH_W-1:0][DATA_W:0]   byp1, byp2;
   logic [DISPATCH_W-1:0]             lane_ok;
   logic [DISPATCH_W-1:0][IDX_W-1:0]  lane_slot;
   logic                              drop;

   logic [ISSUE_W-1:0]                iss_valid;
   logic [ISSUE_W*DATA_W-1:0]         iss_op1, iss_op2;
   logic [ISSUE_W*PRN_W-1:0]          iss_dest;
   logic [ISSUE_W*ROB_W-1:0]          iss_rob;
   logic [ISSUE_W*FUNC_W-1:0]         iss_func;

   // Returns {hit, value}; scanning channels high to low lets the lowest matching channel win.
   function automatic logic [DATA_W:0] cdb_lookup(
      input logic [PRN_W-1:0]        tag,
      input logic [CDB_W-1:0]        vld,
      input logic [CDB_W*PRN_W-1:0]  prn,
      input logic [CDB_W*DATA_W-1:0] val
   );
      logic [DATA_W:0] res;
      res = '0;
      for (int c = CDB_W - 1; c >= 0; c--) begin
         if (vld[c] && prn[c*PRN_W +: PRN_W] == tag) res = {1'b1, val[c*DATA_W +: DATA_W]};
      end
      return res;
   endfunction

   always_comb begin
      ready = valid_q & rdy1_q & rdy2_q;
      for (int i = 0; i < ENTRIES; i++) begin
         rank[i] = '0;
         for (int j = 0; j < ENTRIES; j++) begin
            if (ready[j] && older_q[i][j]) rank[i] = rank[i] + CNT_W'(1);
         end
      end
      slot[0] = '0;
      for (int k = 1; k < ISSUE_W; k++) slot[k] = slot[k-1] + CNT_W'(rs_if.fu_avail[k-1]);
   end

   // Available lane k takes the ready entry whose age rank equals the count of available lanes below it.
   always_comb begin
      issued    = '0;
      iss_valid = '0;
      iss_op1   = '0;
      iss_op2   = '0;
      iss_dest  = '0;
      iss_rob   = '0;
      iss_func  = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (!flush_i && rs_if.fu_avail[k] && ready[i] && rank[i] == slot[k]) begin
               iss_valid[k]                   = 1'b1;
               iss_op1[k*DATA_W +: DATA_W]    = op1_q[i];
               iss_op2[k*DATA_W +: DATA_W]    = op2_q[i];
               iss_dest[k*PRN_W +: PRN_W]     = dest_q[i];
               iss_rob[k*ROB_W +: ROB_W]      = rob_q[i];
               iss_func[k*FUNC_W +: FUNC_W]   = func_q[i];
               issued[i]                      = 1'b1;
            end
         end
      end
   end

   assign rs_if.iss_valid    = iss_valid;
   assign rs_if.iss_op1      = iss_op1;
   assign rs_if.iss_op2      = iss_op2;
   assign rs_if.iss_dest_prn = iss_dest;
   assign rs_if.iss_rob      = iss_rob;
   assign rs_if.iss_func     = iss_func;

   always_comb begin
      for (int e = 0; e < ENTRIES; e++) begin
         wake1[e] = cdb_lookup(op1_q[e][PRN_W-1:0], rs_if.cdb_valid, rs_if.cdb_prn, rs_if.cdb_value);
         wake2[e] = cdb_lookup(op2_q[e][PRN_W-1:0], rs_if.cdb_valid, rs_if.cdb_prn, rs_if.cdb_value);
      end
      for (int l = 0; l < DISPATCH_W; l++) begin
         byp1[l] = cdb_lookup(rs_if.disp_op1[l*DATA_W +: PRN_W], rs_if.cdb_valid, rs_if.cdb_prn,
                              rs_if.cdb_value);
         byp2[l] = cdb_lookup(rs_if.disp_op2[l*DATA_W +: PRN_W], rs_if.cdb_valid, rs_if.cdb_prn,
                              rs_if.cdb_value);
      end
   end

   // Only slots free at the start of the cycle are allocatable; slots issued now reopen next cycle.
   always_comb begin
      taken     = '0;
      lane_ok   = '0;
      lane_slot = '0;
      drop      = 1'b0;
      for (int l = 0; l < DISPATCH_W; l++) begin
         if (rs_if.disp_valid[l]) begin
            for (int e = 0; e < ENTRIES; e++) begin
               if (!lane_ok[l] && !valid_q[e] && !taken[e]) begin
                  lane_ok[l]   = 1'b1;
                  lane_slot[l] = IDX_W'(e);
                  taken[e]     = 1'b1;
               end
            end
            if (!lane_ok[l]) drop = 1'b1;
         end
      end
   end

   always_comb begin
      valid_d  = valid_q & ~issued;
      rdy1_d   = rdy1_q;
      rdy2_d   = rdy2_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      dest_d   = dest_q;
      rob_d    = rob_q;
      func_d   = func_q;
      older_d  = older_q;
      ovf_d    = ovf_q | (drop && !flush_i);
      new_mask = '0;
      for (int e = 0; e < ENTRIES; e++) begin
         if (valid_q[e] && !rdy1_q[e] && wake1[e][DATA_W]) begin
            rdy1_d[e] = 1'b1;
            op1_d[e]  = wake1[e][DATA_W-1:0];
         end
         if (valid_q[e] && !rdy2_q[e] && wake2[e][DATA_W]) begin
            rdy2_d[e] = 1'b1;
            op2_d[e]  = wake2[e][DATA_W-1:0];
         end
      end
      for (int l = 0; l < DISPATCH_W; l++) begin
         if (lane_ok[l]) begin
            valid_d[lane_slot[l]] = 1'b1;
            rdy1_d[lane_slot[l]]  = rs_if.disp_op1_ready[l] | byp1[l][DATA_W];
            rdy2_d[lane_slot[l]]  = rs_if.disp_op2_ready[l] | byp2[l][DATA_W];
            op1_d[lane_slot[l]]   = (!rs_if.disp_op1_ready[l] && byp1[l][DATA_W]) ?
                                    byp1[l][DATA_W-1:0] : rs_if.disp_op1[l*DATA_W +: DATA_W];
            op2_d[lane_slot[l]]   = (!rs_if.disp_op2_ready[l] && byp2[l][DATA_W]) ?
                                    byp2[l][DATA_W-1:0] : rs_if.disp_op2[l*DATA_W +: DATA_W];
            dest_d[lane_slot[l]]  = rs_if.disp_dest_prn[l*PRN_W +: PRN_W];
            rob_d[lane_slot[l]]   = rs_if.disp_rob[l*ROB_W +: ROB_W];
            func_d[lane_slot[l]]  = rs_if.disp_func[l*FUNC_W +: FUNC_W];
            // The newcomer is younger than everything resident and than lower lanes of this cycle.
            for (int i = 0; i < ENTRIES; i++) older_d[i][lane_slot[l]] = 1'b0;
            older_d[lane_slot[l]]  = valid_q | new_mask;
            new_mask[lane_slot[l]] = 1'b1;
         end
      end
      if (flush_i) begin
         valid_d = '0;
         older_d = '0;
      end
      free_d = CNT_W'(ENTRIES);
      for (int e = 0; e < ENTRIES; e++) begin
         if (valid_d[e]) free_d = free_d - CNT_W'(1);
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         valid_q <= '0;
         rdy1_q  <= '0;
         rdy2_q  <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         dest_q  <= '0;
         rob_q   <= '0;
         func_q  <= '0;
         older_q <= '0;
         free_q  <= CNT_W'(ENTRIES);
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         rdy1_q  <= rdy1_d;
         rdy2_q  <= rdy2_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         dest_q  <= dest_d;
         rob_q   <= rob_d;
         func_q  <= func_d;
         older_q <= older_d;
         free_q  <= free_d;
         ovf_q   <= ovf_d;
      end
   end

   assign free_cnt_o     = free_q;
   assign almost_full_o  = (free_q < CNT_W'(DISPATCH_W));
   assign overflow_err_o = ovf_q;

endmodule

// File: tb/tb_rs_age_issue.sv
// tb/tb_rs_age_issue.sv - self-checking bench for rs_age_issue with an age-ordered queue reference model
module tb_rs_age_issue;
   localparam int ENTRIES = 16, DISPATCH_W = 2, CDB_W = 2, ISSUE_W = 2;
   localparam int DATA_W = 32, PRN_W = 6, ROB_W = 5, FUNC_W = 4;
   localparam int CNT_W = $clog2(ENTRIES + 1);

   logic clock = 1'b0, reset_n = 1'b0, flush = 1'b0;
   logic [CNT_W-1:0] free_cnt;
   logic almost_full, overflow_err;

   rs_age_issue_if #(.DISPATCH_W(DISPATCH_W), .CDB_W(CDB_W), .ISSUE_W(ISSUE_W), .DATA_W(DATA_W),
                     .PRN_W(PRN_W), .ROB_W(ROB_W), .FUNC_W(FUNC_W)) bus ();

   rs_age_issue #(.ENTRIES(ENTRIES), .DISPATCH_W(DISPATCH_W), .CDB_W(CDB_W), .ISSUE_W(ISSUE_W),
                  .DATA_W(DATA_W), .PRN_W(PRN_W), .ROB_W(ROB_W), .FUNC_W(FUNC_W)) dut (
      .clock_i(clock), .reset_n_i(reset_n), .flush_i(flush), .rs_if(bus),
      .free_cnt_o(free_cnt), .almost_full_o(almost_full), .overflow_err_o(overflow_err));

   always #5 clock = ~clock;

   typedef struct {
      logic r1, r2;
      logic [DATA_W-1:0] v1, v2;
      logic [PRN_W-1:0] dest;
      logic [ROB_W-1:0] rob;
      logic [FUNC_W-1:0] func;
   } ent_t;

   typedef struct {
      logic [1:0] dv;
      int exp_free;
      logic exp_af;
      logic exp_ovf;
   } fill_vec_t;

   ent_t mq[$];
   logic m_ovf = 1'b0;
   int exp_idx[ISSUE_W];
   int pass_cnt = 0, total = 0;
   fill_vec_t fv[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic idle();
      flush = 1'b0;
      bus.disp_valid = '0; bus.disp_op1_ready = '0; bus.disp_op2_ready = '0;
      bus.disp_op1 = '0; bus.disp_op2 = '0; bus.disp_dest_prn = '0; bus.disp_rob = '0;
      bus.disp_func = '0; bus.cdb_valid = '0; bus.cdb_prn = '0; bus.cdb_value = '0;
      bus.fu_avail = '0;
   endtask

   task automatic set_lane(input int l, input logic r1, input logic [DATA_W-1:0] o1, input logic r2,
                           input logic [DATA_W-1:0] o2, input logic [ROB_W-1:0] rob);
      bus.disp_valid[l] = 1'b1;
      bus.disp_op1_ready[l] = r1;
      bus.disp_op2_ready[l] = r2;
      bus.disp_op1[l*DATA_W +: DATA_W] = o1;
      bus.disp_op2[l*DATA_W +: DATA_W] = o2;
      bus.disp_dest_prn[l*PRN_W +: PRN_W] = PRN_W'($urandom);
      bus.disp_rob[l*ROB_W +: ROB_W] = rob;
      bus.disp_func[l*FUNC_W +: FUNC_W] = FUNC_W'($urandom);
   endtask

   task automatic set_cdb(input int c, input logic [PRN_W-1:0] prn, input logic [DATA_W-1:0] val);
      bus.cdb_valid[c] = 1'b1;
      bus.cdb_prn[c*PRN_W +: PRN_W] = prn;
      bus.cdb_value[c*DATA_W +: DATA_W] = val;
   endtask

   function automatic ent_t wake_ent(input ent_t e);
      ent_t w = e;
      for (int c = CDB_W - 1; c >= 0; c--) begin
         if (bus.cdb_valid[c]) begin
            if (!e.r1 && bus.cdb_prn[c*PRN_W +: PRN_W] == e.v1[PRN_W-1:0]) begin
               w.r1 = 1'b1; w.v1 = bus.cdb_value[c*DATA_W +: DATA_W];
            end
            if (!e.r2 && bus.cdb_prn[c*PRN_W +: PRN_W] == e.v2[PRN_W-1:0]) begin
               w.r2 = 1'b1; w.v2 = bus.cdb_value[c*DATA_W +: DATA_W];
            end
         end
      end
      return w;
   endfunction

   // Ready entries in queue (age) order go to available lanes in ascending order.
   task automatic model_predict();
      int rl[$];
      int p = 0;
      for (int i = 0; i < mq.size(); i++) if (mq[i].r1 && mq[i].r2) rl.push_back(i);
      for (int l = 0; l < ISSUE_W; l++) begin
         exp_idx[l] = -1;
         if (!flush && bus.fu_avail[l] && p < rl.size()) begin
            exp_idx[l] = rl[p];
            p++;
         end
      end
   endtask

   task automatic settle();
      #1;
      model_predict();
      for (int l = 0; l < ISSUE_W; l++) begin
         chk($sformatf("iss_valid[%0d]", l), 64'(bus.iss_valid[l]), 64'(exp_idx[l] >= 0));
         if (exp_idx[l] >= 0) begin
            chk($sformatf("iss_op1[%0d]", l), 64'(bus.iss_op1[l*DATA_W +: DATA_W]), 64'(mq[exp_idx[l]].v1));
            chk($sformatf("iss_op2[%0d]", l), 64'(bus.iss_op2[l*DATA_W +: DATA_W]), 64'(mq[exp_idx[l]].v2));
            chk($sformatf("iss_tags[%0d]", l),
                64'({bus.iss_dest_prn[l*PRN_W +: PRN_W], bus.iss_rob[l*ROB_W +: ROB_W],
                     bus.iss_func[l*FUNC_W +: FUNC_W]}),
                64'({mq[exp_idx[l]].dest, mq[exp_idx[l]].rob, mq[exp_idx[l]].func}));
         end
      end
   endtask

   task automatic tick();
      ent_t nq[$];
      ent_t e;
      int nfree;
      bit is_iss;
      model_predict();
      if (!flush) begin
         nfree = ENTRIES - mq.size();
         for (int i = 0; i < mq.size(); i++) begin
            is_iss = 0;
            for (int l = 0; l < ISSUE_W; l++) if (exp_idx[l] == i) is_iss = 1;
            if (!is_iss) nq.push_back(wake_ent(mq[i]));
         end
         for (int l = 0; l < DISPATCH_W; l++) begin
            if (bus.disp_valid[l]) begin
               if (nfree > 0) begin
                  e.r1 = bus.disp_op1_ready[l]; e.v1 = bus.disp_op1[l*DATA_W +: DATA_W];
                  e.r2 = bus.disp_op2_ready[l]; e.v2 = bus.disp_op2[l*DATA_W +: DATA_W];
                  e.dest = bus.disp_dest_prn[l*PRN_W +: PRN_W];
                  e.rob = bus.disp_rob[l*ROB_W +: ROB_W];
                  e.func = bus.disp_func[l*FUNC_W +: FUNC_W];
                  nq.push_back(wake_ent(e));
                  nfree--;
               end else m_ovf = 1'b1;
            end
         end
      end
      mq = nq;
      @(posedge clock);
      #1;
      chk("free_cnt", 64'(free_cnt), 64'(ENTRIES - mq.size()));
      chk("almost_full", 64'(almost_full), 64'((ENTRIES - mq.size()) < DISPATCH_W));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
   endtask

   task automatic async_reset();
      idle();
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_free_cnt", 64'(free_cnt), 64'(ENTRIES));
      chk("rst_overflow", 64'(overflow_err), 64'(0));
      chk("rst_almost_full", 64'(almost_full), 64'(0));
      mq.delete();
      m_ovf = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic r1, r2;
      logic [DATA_W-1:0] o1, o2;
      idle();
      #12;
      chk("reset_free_cnt", 64'(free_cnt), 64'(ENTRIES));
      chk("reset_almost_full", 64'(almost_full), 64'(0));
      chk("reset_overflow", 64'(overflow_err), 64'(0));
      chk("reset_iss_valid", 64'(bus.iss_valid), 64'(0));
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Fill with fu_avail=0, then overflow once full.
      for (int i = 0; i < 7; i++) fv[i] = '{2'b11, 14 - 2 * i, 1'b0, 1'b0};
      fv[7] = '{2'b01, 1, 1'b1, 1'b0};
      fv[8] = '{2'b01, 0, 1'b1, 1'b0};
      fv[9] = '{2'b11, 0, 1'b1, 1'b1};
      for (int i = 0; i < 10; i++) begin
         idle();
         for (int l = 0; l < DISPATCH_W; l++)
            if (fv[i].dv[l]) set_lane(l, 1'b1, $urandom, 1'b1, $urandom, ROB_W'(2 * i + l));
         settle();
         tick();
         chk($sformatf("fill_free[%0d]", i), 64'(free_cnt), 64'(fv[i].exp_free));
         chk($sformatf("fill_af[%0d]", i), 64'(almost_full), 64'(fv[i].exp_af));
         chk($sformatf("fill_ovf[%0d]", i), 64'(overflow_err), 64'(fv[i].exp_ovf));
      end
      async_reset();

      // Age order: A, B, C wait on tag 5, woken together, issued one per cycle oldest first.
      idle(); set_lane(0, 1'b0, 32'h0000_0005, 1'b1, 32'h100, 5'd1); settle(); tick();
      idle(); set_lane(0, 1'b0, 32'hFFFF_0005, 1'b1, 32'h200, 5'd2); settle(); tick();
      idle(); set_lane(0, 1'b0, 32'h0000_0045, 1'b1, 32'h300, 5'd3); settle(); tick();
      idle(); set_cdb(0, 6'd5, 32'h55); bus.fu_avail = 2'b01; settle();
      chk("age_c3_none", 64'(bus.iss_valid), 64'(0)); tick();
      idle(); bus.fu_avail = 2'b01; settle();
      chk("age_c4_valid", 64'(bus.iss_valid), 64'(2'b01));
      chk("age_c4_rob", 64'(bus.iss_rob[0 +: ROB_W]), 64'(1));
      chk("age_c4_op1", 64'(bus.iss_op1[0 +: DATA_W]), 64'(32'h55)); tick();
      idle(); bus.fu_avail = 2'b01; settle();
      chk("age_c5_rob", 64'(bus.iss_rob[0 +: ROB_W]), 64'(2));
      chk("age_c5_op1", 64'(bus.iss_op1[0 +: DATA_W]), 64'(32'h55)); tick();
      async_reset();

      // Same-cycle bypass with two matching channels; channel 0 wins.
      idle(); set_lane(0, 1'b1, 32'h1, 1'b0, 32'h7, 5'd4);
      set_cdb(0, 6'd7, 32'hAB); set_cdb(1, 6'd7, 32'hCD); settle(); tick();
      idle(); bus.fu_avail = 2'b01; settle();
      chk("bypass_valid", 64'(bus.iss_valid), 64'(2'b01));
      chk("bypass_op2", 64'(bus.iss_op2[0 +: DATA_W]), 64'(32'hAB)); tick();

      // Dual-channel wakeup of both operands.
      idle(); set_lane(0, 1'b0, 32'h3, 1'b0, 32'h4, 5'd5); settle(); tick();
      idle(); set_cdb(0, 6'd3, 32'h11); set_cdb(1, 6'd4, 32'h22); settle(); tick();
      idle(); bus.fu_avail = 2'b01; settle();
      chk("dual_valid", 64'(bus.iss_valid), 64'(2'b01));
      chk("dual_op1", 64'(bus.iss_op1[0 +: DATA_W]), 64'(32'h11));
      chk("dual_op2", 64'(bus.iss_op2[0 +: DATA_W]), 64'(32'h22)); tick();
      async_reset();

      // Lane skipping: lane0 unavailable, lane1 takes the oldest.
      idle(); set_lane(0, 1'b1, 32'hA, 1'b1, 32'hB, 5'd10); set_lane(1, 1'b1, 32'hC, 1'b1, 32'hD, 5'd11);
      settle(); tick();
      idle(); set_lane(0, 1'b1, 32'hE, 1'b1, 32'hF, 5'd12); settle(); tick();
      idle(); bus.fu_avail = 2'b10; settle();
      chk("skip_valid", 64'(bus.iss_valid), 64'(2'b10));
      chk("skip_rob1", 64'(bus.iss_rob[ROB_W +: ROB_W]), 64'(10)); tick();
      idle(); bus.fu_avail = 2'b11; settle();
      chk("skip2_valid", 64'(bus.iss_valid), 64'(2'b11));
      chk("skip2_rob", 64'({bus.iss_rob[ROB_W +: ROB_W], bus.iss_rob[0 +: ROB_W]}), 64'({5'd12, 5'd11}));
      tick();
      async_reset();

      // Flush with 6 resident entries and a concurrent 2-lane dispatch.
      for (int i = 0; i < 3; i++) begin
         idle(); set_lane(0, 1'b1, $urandom, 1'b1, $urandom, ROB_W'(i));
         set_lane(1, 1'b1, $urandom, 1'b1, $urandom, ROB_W'(i + 8)); settle(); tick();
      end
      chk("preflush_free", 64'(free_cnt), 64'(10));
      idle(); set_lane(0, 1'b1, 32'h1, 1'b1, 32'h2, 5'd20); set_lane(1, 1'b1, 32'h3, 1'b1, 32'h4, 5'd21);
      flush = 1'b1; bus.fu_avail = 2'b11; settle();
      chk("flush_iss_valid", 64'(bus.iss_valid), 64'(0)); tick();
      chk("flush_free", 64'(free_cnt), 64'(ENTRIES));

      // Randomized traffic against the queue model.
      for (int n = 0; n < 600; n++) begin
         idle();
         for (int l = 0; l < DISPATCH_W; l++) begin
            if ($urandom_range(2, 0) != 0) begin
               r1 = 1'(($urandom_range(2, 0)) == 0); r2 = 1'(($urandom_range(2, 0)) == 0);
               o1 = $urandom; o2 = $urandom;
               if (!r1) o1[PRN_W-1:0] = PRN_W'($urandom_range(7, 0));
               if (!r2) o2[PRN_W-1:0] = PRN_W'($urandom_range(7, 0));
               set_lane(l, r1, o1, r2, o2, ROB_W'($urandom));
            end
         end
         for (int c = 0; c < CDB_W; c++)
            if ($urandom_range(1, 0) == 1) set_cdb(c, PRN_W'($urandom_range(7, 0)), $urandom);
         bus.fu_avail = ISSUE_W'($urandom);
         flush = ($urandom_range(39, 0) == 0);
         settle();
         tick();
         if (n == 300) async_reset();
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
